// File: rtl/fft_stage_sequencer.sv
// Butterfly command sequencer for one mixed-radix FFT transform: walks the
// radix-2, radix-3 then radix-5 stages and issues one butterfly per accepted handshake.
module fft_stage_sequencer #(
   parameter int PTS_W = 11,
   parameter int ST_W  = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       stages2,
   input  logic [2:0]       stages3,
   input  logic [1:0]       stages5,
   input  logic [PTS_W-1:0] points,
   input  logic             bfly_ready,
   input  logic             dp_idle,
   output logic             busy,
   output logic             bfly_valid,
   output logic [1:0]       radix,
   output logic [ST_W-1:0]  stage_idx,
   output logic [PTS_W-1:0] bfly_idx,
   output logic [PTS_W-1:0] stride,
   output logic             done,
   output logic             err
);

   typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_DRAIN, S_DONE} state_t;

   state_t           state, state_nxt;
   logic [3:0]       rem2, rem2_d;
   logic [2:0]       rem3, rem3_d;
   logic [1:0]       rem5, rem5_d;
   logic [PTS_W-1:0] len, acc;
   logic [PTS_W:0]   acc_next;
   logic [2:0]       rval;
   logic             bad, plan_empty, more_stages;

   function automatic logic [1:0] pick_radix(input logic [3:0] n2, input logic [2:0] n3,
                                             input logic [1:0] n5);
      if (|n2)      return 2'd0;
      else if (|n3) return 2'd1;
      else          return 2'd2;
   endfunction

   function automatic logic [2:0] radix_value(input logic [1:0] r);
      case (r)
         2'd0:    return 3'd2;
         2'd1:    return 3'd3;
         default: return 3'd5;
      endcase
   endfunction

   // Shift-add multiply keeps the stride update free of a real multiplier.
   function automatic logic [PTS_W-1:0] scale_stride(input logic [PTS_W-1:0] s, input logic [1:0] r);
      case (r)
         2'd0:    return s << 1;
         2'd1:    return s + (s << 1);
         default: return s + (s << 2);
      endcase
   endfunction

   always_comb begin
      rval        = radix_value(radix);
      acc_next    = {1'b0, acc} + {{(PTS_W-2){1'b0}}, rval};
      rem2_d      = rem2;
      rem3_d      = rem3;
      rem5_d      = rem5;
      case (radix)
         2'd0:    rem2_d = rem2 - 4'd1;
         2'd1:    rem3_d = rem3 - 3'd1;
         default: rem5_d = rem5 - 2'd1;
      endcase
      more_stages = (|rem2_d) || (|rem3_d) || (|rem5_d);
      plan_empty  = (len == '0) || !((|rem2) || (|rem3) || (|rem5));
   end

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_CHECK;
         S_CHECK: state_nxt = plan_empty ? S_DONE : S_ISSUE;
         S_ISSUE: if (bfly_ready && (acc_next >= {1'b0, len})) state_nxt = S_DRAIN;
         S_DRAIN: if (dp_idle) state_nxt = (bad || !more_stages) ? S_DONE : S_ISSUE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign busy       = (state != S_IDLE);
   assign bfly_valid = (state == S_ISSUE);
   assign done       = (state == S_DONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         rem2      <= '0;
         rem3      <= '0;
         rem5      <= '0;
         len       <= '0;
         acc       <= '0;
         radix     <= '0;
         stage_idx <= '0;
         bfly_idx  <= '0;
         stride    <= '0;
         bad       <= 1'b0;
         err       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               rem2 <= stages2;
               rem3 <= stages3;
               rem5 <= stages5;
               len  <= points;
               bad  <= 1'b0;
               err  <= 1'b0;
            end
            S_CHECK: begin
               radix     <= pick_radix(rem2, rem3, rem5);
               stage_idx <= '0;
               bfly_idx  <= '0;
               acc       <= '0;
               stride    <= PTS_W'(1);
               if (plan_empty) err <= 1'b1;
            end
            // Accumulator overshooting points means points is not a multiple of this radix.
            S_ISSUE: if (bfly_ready) begin
               if (acc_next < {1'b0, len}) begin
                  bfly_idx <= bfly_idx + PTS_W'(1);
                  acc      <= acc_next[PTS_W-1:0];
               end else if (acc_next > {1'b0, len}) begin
                  bad <= 1'b1;
               end
            end
            S_DRAIN: if (dp_idle) begin
               if (bad) begin
                  err <= 1'b1;
               end else begin
                  rem2      <= rem2_d;
                  rem3      <= rem3_d;
                  rem5      <= rem5_d;
                  stride    <= scale_stride(stride, radix);
                  stage_idx <= stage_idx + ST_W'(1);
                  bfly_idx  <= '0;
                  acc       <= '0;
                  radix     <= pick_radix(rem2_d, rem3_d, rem5_d);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer: drives stage plans, models the datapath
// handshake and drain, and checks command streams against hand-computed tables.
module tb_fft_stage_sequencer;

   localparam int PTS_W = 11;
   localparam int ST_W  = 4;

   logic             clk = 1'b0;
   logic             reset, start, bfly_ready, dp_idle;
   logic [3:0]       stages2;
   logic [2:0]       stages3;
   logic [1:0]       stages5;
   logic [PTS_W-1:0] points;
   logic             busy, bfly_valid, done, err;
   logic [1:0]       radix;
   logic [ST_W-1:0]  stage_idx;
   logic [PTS_W-1:0] bfly_idx, stride;

   int n_checks = 0;
   int n_fail   = 0;

   int   q_radix[$], q_stage[$], q_bfly[$], q_stride[$];
   int   nvalid, done_cyc, first_valid, stab_viol, drain_viol, busy_viol;
   logic done_err, err_at1;
   bit   timed_out;

   always #5 clk = ~clk;

   fft_stage_sequencer #(.PTS_W(PTS_W), .ST_W(ST_W)) dut (
      .clk(clk), .reset(reset), .start(start),
      .stages2(stages2), .stages3(stages3), .stages5(stages5), .points(points),
      .bfly_ready(bfly_ready), .dp_idle(dp_idle),
      .busy(busy), .bfly_valid(bfly_valid), .radix(radix), .stage_idx(stage_idx),
      .bfly_idx(bfly_idx), .stride(stride), .done(done), .err(err)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int stage_count(input int s);
      int n = 0;
      foreach (q_stage[i]) if (q_stage[i] == s) n++;
      return n;
   endfunction

   // -1 when the stage never appeared, -2 when its commands disagree.
   function automatic int stage_stride(input int s);
      int v = -1;
      foreach (q_stage[i]) if (q_stage[i] == s) begin
         if (v == -1) v = q_stride[i];
         else if (v != q_stride[i]) return -2;
      end
      return v;
   endfunction

   function automatic int stage_radix(input int s);
      int v = -1;
      foreach (q_stage[i]) if (q_stage[i] == s) begin
         if (v == -1) v = q_radix[i];
         else if (v != q_radix[i]) return -2;
      end
      return v;
   endfunction

   function automatic int seq_errors();
      int e = 0, want = 0, cur = -1;
      foreach (q_stage[i]) begin
         if (q_stage[i] != cur) begin
            cur  = q_stage[i];
            want = 0;
         end
         if (q_bfly[i] != want) e++;
         want++;
      end
      return e;
   endfunction

   task automatic apply_reset();
      reset = 1'b1; start = 1'b0; bfly_ready = 1'b0; dp_idle = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;
   endtask

   // Cycle index 0 is the cycle start is driven; index k is sampled #1 after the k-th edge.
   task automatic run_plan(input int pts, input int s2, input int s3, input int s5,
                           input bit toggle_ready, input int idle_hold,
                           input int restart_at, input int budget);
      int               cyc, hold;
      logic             pv, pr;
      logic [1:0]       p_rad;
      logic [ST_W-1:0]  p_st;
      logic [PTS_W-1:0] p_bf, p_sr;
      q_radix.delete(); q_stage.delete(); q_bfly.delete(); q_stride.delete();
      nvalid = 0; done_cyc = -1; first_valid = -1;
      stab_viol = 0; drain_viol = 0; busy_viol = 0;
      done_err = 1'bx; err_at1 = 1'bx; timed_out = 1'b0;
      points = PTS_W'(pts); stages2 = 4'(s2); stages3 = 3'(s3); stages5 = 2'(s5);
      start = 1'b1; bfly_ready = 1'b0; dp_idle = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      points = PTS_W'(7); stages2 = 4'd15; stages3 = 3'd7; stages5 = 2'd3;
      cyc = 1; hold = 0; pv = 1'b0; pr = 1'b0;
      p_rad = '0; p_st = '0; p_bf = '0; p_sr = '0;
      forever begin
         if (cyc == 1) err_at1 = err;
         if (!busy) busy_viol++;
         start      = (cyc == restart_at);
         bfly_ready = toggle_ready ? cyc[0] : 1'b1;
         if (pv && !bfly_valid && idle_hold > 0) hold = idle_hold;
         dp_idle = (hold == 0);
         if (hold > 0) hold--;
         if (bfly_valid && !dp_idle) drain_viol++;
         if (pv && !pr && !bfly_valid) stab_viol++;
         if (bfly_valid) begin
            nvalid++;
            if (first_valid < 0) first_valid = cyc;
            if (pv && !pr && ({p_rad, p_st, p_bf, p_sr} !== {radix, stage_idx, bfly_idx, stride}))
               stab_viol++;
            if (bfly_ready) begin
               q_radix.push_back(int'(radix));
               q_stage.push_back(int'(stage_idx));
               q_bfly.push_back(int'(bfly_idx));
               q_stride.push_back(int'(stride));
            end
         end
         pv = bfly_valid; pr = bfly_ready;
         p_rad = radix; p_st = stage_idx; p_bf = bfly_idx; p_sr = stride;
         if (done) begin
            done_cyc = cyc;
            done_err = err;
            break;
         end
         if (cyc >= budget) begin
            timed_out = 1'b1;
            break;
         end
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0; bfly_ready = 1'b0; dp_idle = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b1; bfly_ready = 1'b1; dp_idle = 1'b1;
      points = PTS_W'(12); stages2 = 4'd2; stages3 = 3'd1; stages5 = 2'd0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({busy, bfly_valid, done, err} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_ctrl: busy/valid/done/err=%b required 0000", {busy, bfly_valid, done, err});
      end
      n_checks++;
      if ({radix, stage_idx, bfly_idx, stride} !== '0) begin
         n_fail++;
         $display("FAIL reset_cmd: radix=%0d stage=%0d bfly=%0d stride=%0d required all 0",
                  radix, stage_idx, bfly_idx, stride);
      end
      reset = 1'b0; start = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release_idle: busy=%b required 0", busy);
      end
   endtask

   task automatic check_plan12(input string tag);
      int exp_cnt[3] = '{6, 6, 4};
      int exp_str[3] = '{1, 2, 4};
      int exp_rad[3] = '{0, 0, 1};
      n_checks++;
      if (timed_out || nvalid !== 16) begin
         n_fail++;
         $display("FAIL %s_valid_cycles: got %0d (timeout=%0d) required 16", tag, nvalid, timed_out);
      end
      // Start cycle is index 0, so the 22nd cycle of the run is index 21.
      n_checks++;
      if (done_cyc !== 21) begin
         n_fail++;
         $display("FAIL %s_done_cycle: got %0d required 21", tag, done_cyc);
      end
      n_checks++;
      if (done_err !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_err: got %b required 0", tag, done_err);
      end
      for (int s = 0; s < 3; s++) begin
         n_checks++;
         if (stage_count(s) !== exp_cnt[s] || stage_stride(s) !== exp_str[s] || stage_radix(s) !== exp_rad[s]) begin
            n_fail++;
            $display("FAIL %s_stage%0d: count=%0d stride=%0d radix=%0d required %0d/%0d/%0d", tag, s,
                     stage_count(s), stage_stride(s), stage_radix(s), exp_cnt[s], exp_str[s], exp_rad[s]);
         end
      end
      n_checks++;
      if (stage_count(3) !== 0 || seq_errors() !== 0) begin
         n_fail++;
         $display("FAIL %s_sequence: extra_stage=%0d seq_errors=%0d required 0/0", tag, stage_count(3), seq_errors());
      end
   endtask

   task automatic test_pts12();
      apply_reset();
      run_plan(12, 2, 1, 0, 1'b0, 0, 5, 200);
      check_plan12("pts12");
      n_checks++;
      if (first_valid !== 2) begin
         n_fail++;
         $display("FAIL pts12_first_valid: got cycle %0d required 2", first_valid);
      end
      n_checks++;
      if (busy_viol !== 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL pts12_busy: low-while-running=%0d busy_after=%b required 0/0", busy_viol, busy);
      end
   endtask

   task automatic test_pts60_ready_toggle();
      int exp_cnt[4] = '{30, 30, 20, 12};
      int exp_str[4] = '{1, 2, 4, 12};
      int exp_rad[4] = '{0, 0, 1, 2};
      apply_reset();
      run_plan(60, 2, 1, 1, 1'b1, 0, 0, 1000);
      n_checks++;
      if (timed_out || done_err !== 1'b0) begin
         n_fail++;
         $display("FAIL pts60_done: timeout=%0d err=%b required 0/0", timed_out, done_err);
      end
      for (int s = 0; s < 4; s++) begin
         n_checks++;
         if (stage_count(s) !== exp_cnt[s] || stage_stride(s) !== exp_str[s] || stage_radix(s) !== exp_rad[s]) begin
            n_fail++;
            $display("FAIL pts60_stage%0d: count=%0d stride=%0d radix=%0d required %0d/%0d/%0d", s,
                     stage_count(s), stage_stride(s), stage_radix(s), exp_cnt[s], exp_str[s], exp_rad[s]);
         end
      end
      n_checks++;
      if (stab_viol !== 0 || seq_errors() !== 0 || q_bfly.size() !== 92) begin
         n_fail++;
         $display("FAIL pts60_handshake: unstable=%0d seq_errors=%0d accepted=%0d required 0/0/92",
                  stab_viol, seq_errors(), q_bfly.size());
      end
   endtask

   task automatic test_pts1200_slow_drain();
      int exp_cnt[7] = '{600, 600, 600, 600, 400, 240, 240};
      int exp_str[7] = '{1, 2, 4, 8, 16, 48, 240};
      int exp_rad[7] = '{0, 0, 0, 0, 1, 2, 2};
      apply_reset();
      run_plan(1200, 4, 1, 2, 1'b0, 5, 0, 6000);
      n_checks++;
      if (timed_out || drain_viol !== 0 || done_err !== 1'b0) begin
         n_fail++;
         $display("FAIL pts1200_drain: timeout=%0d valid_in_drain=%0d err=%b required 0/0/0",
                  timed_out, drain_viol, done_err);
      end
      for (int s = 0; s < 7; s++) begin
         n_checks++;
         if (stage_count(s) !== exp_cnt[s] || stage_stride(s) !== exp_str[s] || stage_radix(s) !== exp_rad[s]) begin
            n_fail++;
            $display("FAIL pts1200_stage%0d: count=%0d stride=%0d radix=%0d required %0d/%0d/%0d", s,
                     stage_count(s), stage_stride(s), stage_radix(s), exp_cnt[s], exp_str[s], exp_rad[s]);
         end
      end
      // 1 CHECK + 3280 issue cycles + 7 drains of 6 cycles each, then DONE.
      n_checks++;
      if (stage_count(7) !== 0 || done_cyc !== 3324) begin
         n_fail++;
         $display("FAIL pts1200_timing: stage7=%0d done_cycle=%0d required 0/3324", stage_count(7), done_cyc);
      end
   endtask

   task automatic test_bad_plan();
      apply_reset();
      run_plan(0, 2, 1, 0, 1'b0, 0, 0, 50);
      n_checks++;
      if (nvalid !== 0 || done_cyc !== 2 || done_err !== 1'b1) begin
         n_fail++;
         $display("FAIL bad_points0: valid=%0d done_cycle=%0d err=%b required 0/2/1", nvalid, done_cyc, done_err);
      end
      n_checks++;
      if (err !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL bad_err_hold: err=%b busy=%b required 1/0", err, busy);
      end
      run_plan(12, 0, 0, 0, 1'b0, 0, 0, 50);
      n_checks++;
      if (nvalid !== 0 || done_cyc !== 2 || done_err !== 1'b1) begin
         n_fail++;
         $display("FAIL bad_no_stages: valid=%0d done_cycle=%0d err=%b required 0/2/1", nvalid, done_cyc, done_err);
      end
      run_plan(12, 2, 1, 0, 1'b0, 0, 0, 200);
      n_checks++;
      if (err_at1 !== 1'b0) begin
         n_fail++;
         $display("FAIL err_clear_on_start: err=%b required 0", err_at1);
      end
      check_plan12("after_bad");
   endtask

   task automatic test_inconsistent_plan();
      apply_reset();
      run_plan(13, 1, 0, 0, 1'b0, 0, 0, 100);
      n_checks++;
      if (timed_out || done_err !== 1'b1) begin
         n_fail++;
         $display("FAIL pts13_err: timeout=%0d err=%b required 0/1", timed_out, done_err);
      end
      n_checks++;
      if (q_bfly.size() !== 7 || stage_count(0) !== 7 || seq_errors() !== 0) begin
         n_fail++;
         $display("FAIL pts13_count: accepted=%0d stage0=%0d seq_errors=%0d required 7/7/0",
                  q_bfly.size(), stage_count(0), seq_errors());
      end
   endtask

   task automatic test_reset_mid_issue();
      int seen = 0;
      apply_reset();
      points = PTS_W'(12); stages2 = 4'd2; stages3 = 3'd1; stages5 = 2'd0;
      bfly_ready = 1'b1; dp_idle = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      n_checks++;
      if (bfly_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL midreset_precondition: bfly_valid=%b required 1", bfly_valid);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if ({busy, bfly_valid, done, err, radix, stage_idx, bfly_idx, stride} !== '0) begin
         n_fail++;
         $display("FAIL midreset_outputs: busy=%b valid=%b done=%b err=%b radix=%0d stage=%0d bfly=%0d stride=%0d required all 0",
                  busy, bfly_valid, done, err, radix, stage_idx, bfly_idx, stride);
      end
      reset = 1'b0;
      repeat (30) begin
         @(posedge clk); #1;
         if (done || bfly_valid || busy) seen++;
      end
      n_checks++;
      if (seen !== 0) begin
         n_fail++;
         $display("FAIL midreset_abandon: active cycles after reset=%0d required 0", seen);
      end
      run_plan(12, 2, 1, 0, 1'b0, 0, 0, 200);
      check_plan12("after_reset");
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; bfly_ready = 1'b0; dp_idle = 1'b1;
      points = '0; stages2 = '0; stages3 = '0; stages5 = '0;
      test_reset();
      test_pts12();
      test_pts60_ready_toggle();
      test_pts1200_slow_drain();
      test_bad_plan();
      test_inconsistent_plan();
      test_reset_mid_issue();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
